// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and helpers for the ALU operation sequencer.
package alu_seq_pkg;

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

  // The external ALU only defines carry/borrow for ADD and SUB.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DATA_W register file: two combinational read ports, one synchronous write port.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     raddr_a,
  input  logic [IW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven sequencer for the external 4-bit ALU: latch operands, settle, capture, respond.
// Optional build macro ALU_SEQ_STATS_EN adds saturating op_count / zero_count outputs.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_dst,
  input  logic [$clog2(NREG)-1:0] cmd_src_a,
  input  logic [$clog2(NREG)-1:0] cmd_src_b,
  input  logic                    cmd_imm_en,
  input  logic [3:0]              cmd_imm,
  output logic [3:0]              alu_a,
  output logic [3:0]              alu_b,
  output logic [2:0]              alu_s,
  input  logic [3:0]              alu_out,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_data,
  output logic                    rsp_carry,
  output logic                    rsp_zero,
  output logic                    busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]              op_count,
  output logic [7:0]              zero_count
`endif
);

  localparam int         IW        = $clog2(NREG);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t            state;
  logic [IW-1:0]     dst_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  alu_seq_regfile #(.NREG(NREG), .IW(IW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (state == WB),
    .waddr   (dst_q),
    .wdata   (alu_out),
    .raddr_a (cmd_src_a),
    .raddr_b (cmd_src_b),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // alu_a/alu_b/alu_s double as the latched operands and opcode until the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= OP_ADD;
      dst_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= EXEC;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            alu_a     <= rd_a;
            alu_b     <= cmd_imm_en ? cmd_imm : rd_b;
            alu_s     <= cmd_op;
            dst_q     <= cmd_dst;
            cnt       <= SETTLE_LD;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) state <= WB;
          else             cnt   <= cnt - 4'd1;
        end
        WB: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_carry <= op_has_carry(alu_s) & alu_carry;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= OP_ADD;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count   <= '0;
      zero_count <= '0;
    end else if (state == WB) begin
      op_count <= sat_inc(op_count);
      if (alu_zero) zero_count <= sat_inc(zero_count);
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with an in-bench ALU and a transaction-level reference model.
module tb_alu_op_sequencer;

  localparam int NREG   = 4;
  localparam int SETTLE = 1;
  localparam int IW     = $clog2(NREG);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic          cmd_imm_en;
  logic [3:0]    cmd_imm;
  logic [3:0]    alu_a, alu_b;
  logic [2:0]    alu_s;
  logic [3:0]    alu_out;
  logic          alu_carry, alu_zero;
  logic          rsp_valid, rsp_ready;
  logic [3:0]    rsp_data;
  logic          rsp_carry, rsp_zero, busy;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]    op_count, zero_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.NREG(NREG), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count), .zero_count(zero_count)
`endif
  );

  // External ALU stand-in; it drives carry=1 on logic ops so the sequencer's masking is exercised.
  always_comb begin
    alu_out   = 4'd0;
    alu_carry = 1'b0;
    case (alu_s)
      3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: begin alu_out = alu_a & alu_b; alu_carry = 1'b1; end
      3'b011: begin alu_out = alu_a | alu_b; alu_carry = 1'b1; end
      3'b100: {alu_carry, alu_out} = {1'b0, alu_a} + 5'd1;
      3'b101: {alu_carry, alu_out} = {1'b0, alu_a} - 5'd1;
      3'b110: begin alu_out = alu_a ^ alu_b; alu_carry = 1'b1; end
      default: begin alu_out = ~alu_a; alu_carry = 1'b1; end
    endcase
  end
  assign alu_zero = (alu_out == 4'd0);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {carry, zero, data} from the opcode table; carry only meaningful for ADD/SUB.
  function automatic logic [5:0] ref_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    logic       c;
    c = 1'b0;
    case (op)
      3'd0: begin d = a + b; c = ({1'b0, a} + {1'b0, b}) > 5'd15; end
      3'd1: begin d = a - b; c = (a < b); end
      3'd2: d = a & b;
      3'd3: d = a | b;
      3'd4: d = a + 4'd1;
      3'd5: d = a - 4'd1;
      3'd6: d = a ^ b;
      default: d = ~a;
    endcase
    return {c, (d == 4'd0), d};
  endfunction

  // Reference model state: register contents and the single outstanding transaction.
  logic [3:0] mreg [NREG];
  bit         outstanding = 1'b0;
  int         acc_cyc = 0;
  int         hs_cyc = 0;
  logic [3:0] e_a, e_b, e_data;
  logic [2:0] e_s;
  logic       e_c, e_z;

  always @(negedge clk) begin
    bit         exp_rv;
    logic [5:0] r;
    logic [3:0] bop;
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mreg[i] = 4'd0;
      outstanding = 1'b0;
      chk("rst_rsp_data", {4'd0, rsp_data}, 8'd0);
      chk("rst_rsp_flags", {6'd0, rsp_carry, rsp_zero}, 8'd0);
    end
    exp_rv = outstanding && ((cyc - acc_cyc) >= 2 + SETTLE);
    chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, !outstanding});
    chk("busy", {7'd0, busy}, {7'd0, outstanding});
    chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, exp_rv});
    if (!outstanding) begin
      chk("idle_alu", {1'b0, alu_s, alu_a | alu_b}, 8'd0);
    end else if (!exp_rv) begin
      chk("alu_a", {4'd0, alu_a}, {4'd0, e_a});
      chk("alu_b", {4'd0, alu_b}, {4'd0, e_b});
      chk("alu_s", {5'd0, alu_s}, {5'd0, e_s});
    end
    if (exp_rv) begin
      chk("rsp_data", {4'd0, rsp_data}, {4'd0, e_data});
      chk("rsp_carry", {7'd0, rsp_carry}, {7'd0, e_c});
      chk("rsp_zero", {7'd0, rsp_zero}, {7'd0, e_z});
    end
    if (rst_n && outstanding && rsp_valid && rsp_ready) begin
      outstanding = 1'b0;
      hs_cyc = cyc;
    end else if (rst_n && !outstanding && cmd_valid && cmd_ready) begin
      bop = cmd_imm_en ? cmd_imm : mreg[cmd_src_b];
      e_a = mreg[cmd_src_a];
      e_b = bop;
      e_s = cmd_op;
      r = ref_op(cmd_op, e_a, bop);
      e_c = r[5];
      e_z = r[4];
      e_data = r[3:0];
      mreg[cmd_dst] = e_data;
      outstanding = 1'b1;
      acc_cyc = cyc;
    end
  end

  task automatic issue(input logic [2:0] op, input int dst, input int sa, input int sb,
                       input logic ie, input logic [3:0] imm);
    cmd_op = op; cmd_dst = IW'(dst); cmd_src_a = IW'(sa); cmd_src_b = IW'(sb);
    cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 50);
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles", cmd_ready, n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, output logic [3:0] d, output logic c, output logic z);
    int n = 0;
    rsp_ready = (hold == 0);
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: rsp_valid still %0b after %0d cycles", rsp_valid, n);
      rsp_ready = 1'b1; d = 4'd0; c = 1'b0; z = 1'b0;
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    d = rsp_data; c = rsp_carry; z = rsp_zero;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [2:0] op, input int dst, input int sa, input int sb,
                     input logic ie, input logic [3:0] imm, input int hold,
                     output logic [3:0] d, output logic c, output logic z);
    issue(op, dst, sa, sb, ie, imm);
    wait_accept();
    get_rsp(hold, d, c, z);
  endtask

  initial begin
    logic [3:0] d;
    logic       c, z;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm_en = 1'b0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rsp_valid, busy, alu_s, 3'd0}, 8'd0);
    chk("reset_ready", {7'd0, cmd_ready}, 8'd1);
    chk("reset_alu", {alu_a, alu_b}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < NREG; r++) begin
      run(3'b011, r, r, 0, 1'b1, 4'h0, 0, d, c, z);
      chk("readback_zero", {3'd0, z, d}, 8'h10);
    end

    run(3'b011, 0, 0, 0, 1'b1, 4'h9, 0, d, c, z);
    run(3'b011, 1, 1, 0, 1'b1, 4'h8, 0, d, c, z);
    run(3'b000, 2, 0, 1, 1'b0, 4'h0, 0, d, c, z);
    chk("add_9_8", {2'd0, c, z, d}, 8'h21);

    run(3'b010, 0, 0, 0, 1'b1, 4'h0, 0, d, c, z);
    run(3'b011, 0, 0, 0, 1'b1, 4'h3, 0, d, c, z);
    run(3'b001, 0, 0, 0, 1'b1, 4'h5, 0, d, c, z);
    chk("sub_3_5", {2'd0, c, z, d}, 8'h2E);
    run(3'b111, 1, 3, 0, 1'b0, 4'h0, 0, d, c, z);
    chk("not_0", {2'd0, c, z, d}, 8'h0F);

    run(3'b011, 3, 3, 0, 1'b1, 4'hF, 0, d, c, z);
    run(3'b100, 3, 3, 0, 1'b0, 4'h0, 0, d, c, z);
    chk("inc_wrap", {2'd0, c, z, d}, 8'h10);
    run(3'b011, 3, 3, 0, 1'b1, 4'h0, 0, d, c, z);
    chk("r3_after_inc", {3'd0, z, d}, 8'h10);

    // Backpressure with a second command waiting on cmd_valid.
    issue(3'b110, 1, 1, 0, 1'b1, 4'h5);
    wait_accept();
    issue(3'b000, 2, 1, 1, 1'b0, 4'h0);
    get_rsp(5, d, c, z);
    chk("bp_xor", {3'd0, z, d}, 8'h0A);
    wait_accept();
    chk("b2b_accept_gap", 8'(acc_cyc - hs_cyc), 8'd1);
    get_rsp(0, d, c, z);
    chk("bp_add", {2'd0, c, z, d}, 8'h24);

    // Reset landing in EXEC.
    issue(3'b011, 2, 2, 0, 1'b1, 4'h7);
    wait_accept();
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {rsp_valid, busy, cmd_ready, 5'd0}, 8'h20);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(3'b011, 2, 2, 0, 1'b1, 4'h0, 0, d, c, z);
    chk("midrst_dst", {3'd0, z, d}, 8'h10);

    for (int k = 0; k < 60; k++) begin
      run(3'($urandom_range(0, 7)), $urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
          $urandom_range(0, NREG-1), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), d, c, z);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-driven controller that sequences the team's 4-bit combinational ALU.
- Accepts one operation per valid/ready command and reads operands from a small internal register file or an immediate.
- Drives the ALU opcode and operand buses, holds them for a settle window, then captures the result and flags.
- Writes the result back to a destination register and returns result plus flags on a valid/ready response channel.
- Sits between a host/test controller and the ALU; the ALU stays external to this block.

Parameters:
- NREG, 4, number of 4-bit general registers (power of 2, 2..16).
- SETTLE, 1, cycles the ALU inputs are held stable before capture (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 INC, 101 DEC, 110 XOR, 111 NOT.
- cmd_dst  in  $clog2(NREG)  destination register index.
- cmd_src_a  in  $clog2(NREG)  operand A register index.
- cmd_src_b  in  $clog2(NREG)  operand B register index.
- cmd_imm_en  in  1  1: operand B = cmd_imm instead of the register.
- cmd_imm  in  4  immediate operand.
- alu_a  out  4  to ALU operand a.
- alu_b  out  4  to ALU operand b.
- alu_s  out  3  to ALU opcode s.
- alu_out  in  4  from ALU result.
- alu_carry  in  1  from ALU carry/borrow.
- alu_zero  in  1  from ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  4  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  captured zero.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock `clk`; `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, all registers 0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=0, alu_a=alu_b=0, alu_s=000, busy=0.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch op, dst, A = reg[src_a], B = imm_en ? imm : reg[src_b].
  - Go to EXEC.
- EXEC:
  - alu_a, alu_b, alu_s are registered outputs, driven from the latched values, and stable for the whole state.
  - A settle counter loads SETTLE-1 on entry and decrements.
  - At 0, go to WB.
- WB, one cycle:
  - Capture alu_out into rsp_data and reg[dst].
  - rsp_zero = alu_zero.
  - rsp_carry = alu_carry for op 000/001 only; 0 for every other op, because the ALU does not define carry for those.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data/flags held stable until the handshake.
  - On rsp_ready, rsp_valid drops next cycle and the FSM returns to IDLE.
  - alu_* buses return to 0 in IDLE.
- Latency: command accepted at cycle T → rsp_valid first high at T+2+SETTLE with rsp_ready tied high. Throughput is one command per 3+SETTLE cycles.
- cmd_ready is 0 in EXEC/WB/RESP. Commands offered then are not accepted and must be held by the sender.
- src == dst is legal: operands are latched at accept, and the write occurs in WB.
- Register indices are taken modulo NREG; the index width is exact, so there is no out-of-range case.
- Arithmetic wrap is the ALU's, e.g. INC of F gives 0 with zero=1.
- Reset asserted in any state forces all reset values immediately. A pending response is discarded and a register write in flight is lost.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- Defined:
  - Adds output ports op_count[7:0] and zero_count[7:0].
  - op_count increments on every WB.
  - zero_count increments on WB when the captured zero flag is 1.
  - Both saturate at 255 and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg:
  - opcode localparams (OP_ADD..OP_NOT).
  - state enum (IDLE, EXEC, WB, RESP).
  - function op_has_carry(op).
- Sub-module alu_seq_regfile:
  - NREG x 4 flops.
  - two combinational read ports, one synchronous write port.
  - async active-low clear.

Test Plan:
- Reset: hold rst_n=0 → all outputs at reset values, busy=0, cmd_ready=1; read-back of every register via OR r,r,#0 returns 0.
- ADD with carry: r0=9, r1=8 loaded via OR imm, then ADD r2=r0+r1 → rsp_data=1, carry=1, zero=0; response at T+3 with SETTLE=1.
- SUB borrow and NOT: SUB r0=3, imm 5 → data=E, carry=1; NOT of 0 → data=F, carry=0, zero=0.
- INC wrap: r3=F, INC r3 → data=0, zero=1, carry=0; a following read of r3 returns 0.
- Backpressure:
  - rsp_ready low for 5 cycles → rsp_valid and data stable, cmd_ready=0 throughout.
  - A second command held on cmd_valid is accepted exactly one cycle after the response handshake.
- Reset mid-op: assert rst_n low during EXEC → rsp_valid=0 immediately, dst register stays 0, FSM in IDLE after release.
